freq_gate_ctrl: RTL and testbench

Measurement sequencer for the 6-digit BCD event counter in the frequency meter. It runs on the reference clock and repeats a fixed cycle: clear the counter, open a gate window of exact length, let the counter settle, then latch the BCD count into a holding register and flag it valid. It supports continuous mode (RUN level) and single-shot mode (ONESHOT pulse), and it checks each captured result for saturation and invalid BCD digits.

---
 rtl/freq_gate_ctrl.sv | 155 +++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer for the BCD frequency counter: clear, gate, settle, latch.
// Runs continuously while RUN is high, or once per ONESHOT pulse from idle.
module freq_gate_ctrl #(
    parameter int GATE_CYCLES   = 1000,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RUN,
    input  logic        ONESHOT,
    input  logic [23:0] Q_IN,
    output logic        ENA,
    output logic        CLR,
    output logic [23:0] DOUT,
    output logic        VALID,
    output logic        OVF,
    output logic        BCD_ERR,
    output logic        BUSY
);

    localparam int MAX_A = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
    localparam int MAX_C = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] CLR_LOAD    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_GATE   = 3'd2,
        S_SETTLE = 3'd3,
        S_LATCH  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic          mode_run, mode_next;
    logic          capture;
    logic          abort;

    function automatic logic has_bad_digit(input logic [23:0] q);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (q[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // mode_run records whether RUN started this measurement; only those may abort
    assign abort = mode_run && !RUN;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            timer    <= '0;
            mode_run <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            mode_run <= mode_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        mode_next  = mode_run;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (RUN || ONESHOT) begin
                    state_next = S_CLEAR;
                    timer_next = CLR_LOAD;
                    mode_next  = RUN;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end else if (timer == '0) begin
                    state_next = S_GATE;
                    timer_next = GATE_LOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            S_GATE: begin
                if (abort) begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end else if (timer == '0) begin
                    state_next = S_SETTLE;
                    timer_next = SETTLE_LOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end else if (timer == '0) begin
                    state_next = S_LATCH;
                    timer_next = '0;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            S_LATCH: begin
                capture = 1'b1;
                if (RUN) begin
                    state_next = S_CLEAR;
                    timer_next = CLR_LOAD;
                    mode_next  = 1'b1;
                end else begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_comb begin
        ENA  = (state == S_GATE);
        CLR  = (state == S_IDLE) || (state == S_CLEAR);
        BUSY = (state != S_IDLE);
    end

    // Result register: Q_IN is static here because ENA has been low for SETTLE_CYCLES
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            DOUT    <= '0;
            OVF     <= 1'b0;
            BCD_ERR <= 1'b0;
            VALID   <= 1'b0;
        end else begin
            VALID <= capture;
            if (capture) begin
                DOUT    <= Q_IN;
                OVF     <= (Q_IN == 24'h999999);
                BCD_ERR <= has_bad_digit(Q_IN);
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: table of one-shot captures plus hand sequences
// for reset, continuous mode, abort and ONESHOT corner cases.
module tb_freq_gate_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N, RUN, ONESHOT;
    logic [23:0] Q_IN;
    logic        ENA, CLR, VALID, OVF, BCD_ERR, BUSY;
    logic [23:0] DOUT;
    logic        ena1, clr1, valid1, ovf1, err1, busy1;
    logic [23:0] dout1;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    typedef struct {
        logic [23:0] q;
        logic [23:0] dout;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    always #5 CLK = ~CLK;

    freq_gate_ctrl #(.GATE_CYCLES(10), .CLR_CYCLES(2), .SETTLE_CYCLES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .ONESHOT(ONESHOT), .Q_IN(Q_IN),
        .ENA(ENA), .CLR(CLR), .DOUT(DOUT), .VALID(VALID), .OVF(OVF),
        .BCD_ERR(BCD_ERR), .BUSY(BUSY)
    );

    freq_gate_ctrl #(.GATE_CYCLES(1), .CLR_CYCLES(2), .SETTLE_CYCLES(4)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .ONESHOT(ONESHOT), .Q_IN(Q_IN),
        .ENA(ena1), .CLR(clr1), .DOUT(dout1), .VALID(valid1), .OVF(ovf1),
        .BCD_ERR(err1), .BUSY(busy1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Call right after the edge that started a window (k=0). Returns the k at which
    // VALID is seen (-1 on timeout) and counts ENA / busy-CLR cycles before it.
    task automatic window(input int run_hi_k, input int run_lo_k, input int os_k,
                          output int vk, output int ena_n, output int clr_n,
                          output int ena1_n, output int v1k);
        vk = -1; ena_n = 0; clr_n = 0; ena1_n = 0; v1k = -1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0 && VALID) begin
                vk = k;
                break;
            end
            if (ENA) ena_n++;
            if (CLR && BUSY) clr_n++;
            if (ENA && CLR) overlap++;
            if (ena1) ena1_n++;
            if (valid1 && v1k < 0) v1k = k;
            if (k == run_hi_k) RUN = 1'b1;
            if (k == run_lo_k) RUN = 1'b0;
            ONESHOT = (k == os_k);
            tick();
        end
        ONESHOT = 1'b0;
    endtask

    initial begin
        int vk, en, cn, en1, v1k, vcount, bcount;
        logic [23:0] cont_q[3];

        vecs[0] = '{q: 24'h000123, dout: 24'h000123, ovf: 1'b0, err: 1'b0};
        vecs[1] = '{q: 24'h999999, dout: 24'h999999, ovf: 1'b1, err: 1'b0};
        vecs[2] = '{q: 24'h0A0000, dout: 24'h0A0000, ovf: 1'b0, err: 1'b1};
        vecs[3] = '{q: 24'h000001, dout: 24'h000001, ovf: 1'b0, err: 1'b0};
        vecs[4] = '{q: 24'h12345F, dout: 24'h12345F, ovf: 1'b0, err: 1'b1};
        vecs[5] = '{q: 24'h999998, dout: 24'h999998, ovf: 1'b0, err: 1'b0};
        cont_q[0] = 24'h000456;
        cont_q[1] = 24'h054321;
        cont_q[2] = 24'h100000;

        // Reset held with RUN high
        RST_N = 1'b0; RUN = 1'b1; ONESHOT = 1'b0; Q_IN = 24'h777777;
        repeat (3) tick();
        chk("rst_ena", ENA, 0);
        chk("rst_clr", CLR, 1);
        chk("rst_dout", DOUT, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_err", BCD_ERR, 0);
        chk("rst_ena_g1", ena1, 0);

        // Release: first edge with RUN=1 enters CLEAR, then continuous windows
        RST_N = 1'b1;
        Q_IN = cont_q[0];
        tick();
        chk("rel_busy", BUSY, 1);
        chk("rel_clr", CLR, 1);
        for (int w = 0; w < 3; w++) begin
            Q_IN = cont_q[w];
            window(-1, -1, -1, vk, en, cn, en1, v1k);
            chk($sformatf("cont_period_%0d", w), vk, 17);
            chk($sformatf("cont_dout_%0d", w), DOUT, cont_q[w]);
            chk($sformatf("cont_ena_%0d", w), en, 10);
            chk($sformatf("cont_busy_%0d", w), BUSY, 1);
        end
        chk("cont_no_overlap", overlap, 0);

        // Abort: RUN drops in the 5th GATE cycle (k=6)
        Q_IN = 24'h888888;
        for (int k = 0; k < 6; k++) tick();
        chk("abort_pre_ena", ENA, 1);
        RUN = 1'b0;
        tick();
        chk("abort_busy", BUSY, 0);
        chk("abort_ena", ENA, 0);
        chk("abort_clr", CLR, 1);
        vcount = 0;
        for (int k = 0; k < 25; k++) begin
            if (VALID) vcount++;
            tick();
        end
        chk("abort_no_valid", vcount, 0);
        chk("abort_dout_kept", DOUT, cont_q[2]);

        // Table of one-shot captures
        for (int i = 0; i < 6; i++) begin
            Q_IN = vecs[i].q;
            ONESHOT = 1'b1;
            tick();
            ONESHOT = 1'b0;
            window(-1, -1, -1, vk, en, cn, en1, v1k);
            chk($sformatf("os_valid_at_%0d", i), vk, 17);
            chk($sformatf("os_ena_%0d", i), en, 10);
            chk($sformatf("os_clr_%0d", i), cn, 2);
            chk($sformatf("os_dout_%0d", i), DOUT, vecs[i].dout);
            chk($sformatf("os_ovf_%0d", i), OVF, vecs[i].ovf);
            chk($sformatf("os_err_%0d", i), BCD_ERR, vecs[i].err);
            chk($sformatf("os_idle_%0d", i), BUSY, 0);
            if (i == 0) begin
                chk("g1_ena_cycles", en1, 1);
                chk("g1_valid_at", v1k, 8);
                chk("g1_dout", dout1, 24'h000123);
            end
            tick();
            chk($sformatf("os_valid_pulse_%0d", i), VALID, 0);
        end

        // ONESHOT-started run survives RUN rising then falling mid-gate
        Q_IN = 24'h031415;
        ONESHOT = 1'b1;
        tick();
        ONESHOT = 1'b0;
        window(3, 6, -1, vk, en, cn, en1, v1k);
        chk("os_noabort_valid_at", vk, 17);
        chk("os_noabort_dout", DOUT, 24'h031415);
        chk("os_noabort_idle", BUSY, 0);

        // ONESHOT pulse while busy is ignored
        Q_IN = 24'h000777;
        ONESHOT = 1'b1;
        tick();
        ONESHOT = 1'b0;
        window(-1, -1, 5, vk, en, cn, en1, v1k);
        chk("os_busy_valid_at", vk, 17);
        bcount = 0;
        for (int k = 0; k < 20; k++) begin
            if (BUSY) bcount++;
            tick();
        end
        chk("os_busy_ignored", bcount, 0);

        // RUN and ONESHOT together select continuous mode
        Q_IN = 24'h000042;
        RUN = 1'b1;
        ONESHOT = 1'b1;
        tick();
        ONESHOT = 1'b0;
        window(-1, -1, -1, vk, en, cn, en1, v1k);
        chk("both_valid_at", vk, 17);
        chk("both_continues", BUSY, 1);
        Q_IN = 24'h000043;
        window(-1, -1, -1, vk, en, cn, en1, v1k);
        chk("both_period", vk, 17);
        chk("both_dout", DOUT, 24'h000043);
        RUN = 1'b0;
        tick();
        chk("both_abort_idle", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
